// File: rtl/cache_ctrl_dm.sv
// cache_ctrl_dm
// Control FSM for a direct-mapped, write-back, write-allocate cache. It sits
// between the CPU port and the physical-memory (pmem) port. It sequences the
// line-array write enables and the datain mux, runs the pmem handshakes for
// victim writeback and line fill, and keeps saturating performance counters.
//
// Ports
//   clk, rst_n                  clock (rising edge) and async active-low reset
//   mem_read, mem_write         CPU request, held until mem_resp (both = write)
//   mem_resp                    CPU request complete, one-cycle pulse
//   hit, victim_dirty           status from the line-array datapath
//   pmem_read, pmem_write       pmem fill / writeback request, held until pmem_resp
//   pmem_resp                   pmem transaction done, one-cycle pulse
//   load_data/tag/valid/dirty   line-array write enables (valid writes 1)
//   dirty_in                    value written into the dirty array
//   datain_sel                  0: CPU-merged line, 1: pmem line
//   pmem_addr_sel               0: request address, 1: stored victim tag
//   hit_count, miss_count,
//   wb_count                    saturating hit / miss / writeback counters
//
// Outputs are combinational from state and inputs so that a hit completes in
// the same cycle it is presented. All of them are held low while rst_n is low.
module cache_ctrl_dm #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic                 hit,
    input  logic                 victim_dirty,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    output logic                 load_data,
    output logic                 load_tag,
    output logic                 load_valid,
    output logic                 load_dirty,
    output logic                 dirty_in,
    output logic                 datain_sel,
    output logic                 pmem_addr_sel,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WRITEBACK = 2'b01,
        ST_ALLOCATE  = 2'b10
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic req_s;
    logic hit_inc_s;
    logic miss_inc_s;
    logic wb_inc_s;

    logic mem_resp_s;
    logic pmem_read_s;
    logic pmem_write_s;
    logic load_data_s;
    logic load_tag_s;
    logic load_valid_s;
    logic load_dirty_s;
    logic dirty_in_s;
    logic datain_sel_s;
    logic pmem_addr_sel_s;

    logic [CNT_WIDTH-1:0] hit_count_r;
    logic [CNT_WIDTH-1:0] miss_count_r;
    logic [CNT_WIDTH-1:0] wb_count_r;

    // Saturating increment: an all-ones counter stays put instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    assign req_s = mem_read | mem_write;

    // Next-state, control-output and counter-increment decode.
    always_comb begin
        state_next_s    = state_r;
        hit_inc_s       = 1'b0;
        miss_inc_s      = 1'b0;
        wb_inc_s        = 1'b0;
        mem_resp_s      = 1'b0;
        pmem_read_s     = 1'b0;
        pmem_write_s    = 1'b0;
        load_data_s     = 1'b0;
        load_tag_s      = 1'b0;
        load_valid_s    = 1'b0;
        load_dirty_s    = 1'b0;
        dirty_in_s      = 1'b0;
        datain_sel_s    = 1'b0;
        pmem_addr_sel_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s && hit) begin
                    mem_resp_s = 1'b1;
                    hit_inc_s  = 1'b1;
                    // mem_write wins when both request lines are high.
                    if (mem_write) begin
                        load_data_s  = 1'b1;
                        load_dirty_s = 1'b1;
                        dirty_in_s   = 1'b1;
                    end else begin
                        load_data_s  = 1'b0;
                    end
                end else if (req_s) begin
                    miss_inc_s = 1'b1;
                    if (victim_dirty) begin
                        state_next_s = ST_WRITEBACK;
                    end else begin
                        state_next_s = ST_ALLOCATE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                // Victim address comes from the stored tag.
                pmem_write_s    = 1'b1;
                pmem_addr_sel_s = 1'b1;
                if (pmem_resp) begin
                    wb_inc_s     = 1'b1;
                    state_next_s = ST_ALLOCATE;
                end else begin
                    state_next_s = ST_WRITEBACK;
                end
            end
            ST_ALLOCATE: begin
                // Fill completes even if the CPU has dropped its request;
                // the request is re-checked in IDLE where it now hits.
                pmem_read_s = 1'b1;
                if (pmem_resp) begin
                    load_data_s  = 1'b1;
                    load_tag_s   = 1'b1;
                    load_valid_s = 1'b1;
                    load_dirty_s = 1'b1;
                    datain_sel_s = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ALLOCATE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Reset gating: outputs drop asynchronously with rst_n so no partial
    // line is written and pmem requests vanish at once.
    assign mem_resp      = rst_n & mem_resp_s;
    assign pmem_read     = rst_n & pmem_read_s;
    assign pmem_write    = rst_n & pmem_write_s;
    assign load_data     = rst_n & load_data_s;
    assign load_tag      = rst_n & load_tag_s;
    assign load_valid    = rst_n & load_valid_s;
    assign load_dirty    = rst_n & load_dirty_s;
    assign dirty_in      = rst_n & dirty_in_s;
    assign datain_sel    = rst_n & datain_sel_s;
    assign pmem_addr_sel = rst_n & pmem_addr_sel_s;

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
    assign wb_count   = wb_count_r;

    // State register and saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            hit_count_r  <= {CNT_WIDTH{1'b0}};
            miss_count_r <= {CNT_WIDTH{1'b0}};
            wb_count_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (hit_inc_s) begin
                hit_count_r <= sat_inc(hit_count_r);
            end
            if (miss_inc_s) begin
                miss_count_r <= sat_inc(miss_count_r);
            end
            if (wb_inc_s) begin
                wb_count_r <= sat_inc(wb_count_r);
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Self-checking bench for cache_ctrl_dm. The bench plays the datapath (a
// 16-line tag/valid/dirty model that produces hit and victim_dirty) and the
// pmem (random latency). Each request pushes its expected events (writeback,
// fill, CPU response) into a queue; a monitor pops and checks them as the DUT
// presents them. A second instance with 4-bit counters covers saturation.
module tb_cache_ctrl_dm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, hit, victim_dirty, pmem_resp;
    logic        mem_resp, pmem_read, pmem_write;
    logic        load_data, load_tag, load_valid, load_dirty;
    logic        dirty_in, datain_sel, pmem_addr_sel;
    logic [15:0] hit_count, miss_count, wb_count;

    logic        s_read, s_write, s_hit, s_vd, s_presp;
    logic        s_resp, s_pr, s_pw, s_ld, s_lt, s_lv, s_ldy, s_din, s_dsel, s_asel;
    logic [3:0]  s_hc, s_mc, s_wc;

    cache_ctrl_dm #(.CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .hit(hit), .victim_dirty(victim_dirty),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .load_data(load_data), .load_tag(load_tag), .load_valid(load_valid),
        .load_dirty(load_dirty), .dirty_in(dirty_in), .datain_sel(datain_sel),
        .pmem_addr_sel(pmem_addr_sel), .hit_count(hit_count),
        .miss_count(miss_count), .wb_count(wb_count)
    );

    cache_ctrl_dm #(.CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .mem_read(s_read), .mem_write(s_write),
        .mem_resp(s_resp), .hit(s_hit), .victim_dirty(s_vd),
        .pmem_read(s_pr), .pmem_write(s_pw), .pmem_resp(s_presp),
        .load_data(s_ld), .load_tag(s_lt), .load_valid(s_lv),
        .load_dirty(s_ldy), .dirty_in(s_din), .datain_sel(s_dsel),
        .pmem_addr_sel(s_asel), .hit_count(s_hc),
        .miss_count(s_mc), .wb_count(s_wc)
    );

    always #5 clk = ~clk;

    // Expected event kinds: 0 writeback done, 1 fill done, 2 read resp, 3 write resp
    int   exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   resp_en = 1'b0;

    // Reference cache model (datapath state)
    logic [1:0] m_tag   [16];
    logic       m_valid [16];
    logic       m_dirty [16];
    int         m_hits = 0, m_miss = 0, m_wb = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // pmem responder: random 1..5 cycle latency per transaction
    initial begin
        int wcnt;
        wcnt = 0;
        pmem_resp = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            if (rst_n && resp_en && (pmem_read || pmem_write)) begin
                if (wcnt == 0) wcnt = $urandom_range(1, 5);
                wcnt--;
                if (wcnt == 0) pmem_resp = 1'b1;
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: pops expected events whenever the DUT completes one
    always @(negedge clk) begin : mon_blk
        int   obs;
        int   e;
        logic w;
        if (rst_n) begin
            chk("pmem_exclusive", {31'd0, pmem_read & pmem_write}, 32'd0);
            if (pmem_write) chk("wb_addr_sel", {31'd0, pmem_addr_sel}, 32'd1);
            if (pmem_read)  chk("fill_addr_sel", {31'd0, pmem_addr_sel}, 32'd0);
            obs = -1;
            if (pmem_write && pmem_resp)     obs = 0;
            else if (pmem_read && pmem_resp) obs = 1;
            else if (mem_resp)               obs = 2;
            else if (load_data | load_tag | load_valid | load_dirty)
                chk("spurious_load", {28'd0, load_data, load_tag, load_valid, load_dirty}, 32'd0);
            if (obs >= 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", obs, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_order", obs, (e >= 2) ? 2 : e);
                    w = (e == 3);
                    if (obs == 0)
                        chk("wb_ctl", {28'd0, load_data, load_tag, load_valid, load_dirty}, 32'd0);
                    else if (obs == 1)
                        chk("fill_ctl", {25'd0, load_data, load_tag, load_valid, load_dirty,
                                         datain_sel, dirty_in, mem_resp}, 32'b1111100);
                    else
                        chk("resp_ctl", {24'd0, load_data, load_dirty, dirty_in, datain_sel,
                                         load_tag, load_valid, pmem_read, pmem_write},
                            {24'd0, w, w, w, 5'b00000});
                end
            end
        end
    end

    // One CPU request; abandon drops the request while a fill is in progress
    task automatic do_req(input int idx, input int tg, input logic rd, input logic wr,
                          input bit abandon);
        bit   hm, vd, done, fill_seen, drop_now;
        logic [1:0] t2;
        t2 = tg[1:0];
        hm = m_valid[idx] && (m_tag[idx] == t2);
        vd = m_valid[idx] && m_dirty[idx];
        if (hm) abandon = 1'b0;
        if (hm) begin
            exp_q.push_back(wr ? 3 : 2);
            m_hits++;
        end else begin
            m_miss++;
            if (vd) begin
                exp_q.push_back(0);
                m_wb++;
            end
            exp_q.push_back(1);
            if (!abandon) begin
                exp_q.push_back(wr ? 3 : 2);
                m_hits++;
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = t2;
            m_dirty[idx] = 1'b0;
        end
        if (!abandon && wr) m_dirty[idx] = 1'b1;

        @(posedge clk);
        #1;
        mem_read = rd; mem_write = wr; hit = hm; victim_dirty = vd;
        done = 1'b0; fill_seen = 1'b0; drop_now = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (abandon) begin
                if (pmem_read) drop_now = 1'b1;
                if (pmem_read && pmem_resp) done = 1'b1;
            end else begin
                if (mem_resp) done = 1'b1;
                else if (pmem_read && pmem_resp) fill_seen = 1'b1;
            end
            @(posedge clk);
            #1;
            if (drop_now) begin mem_read = 1'b0; mem_write = 1'b0; end
            if (fill_seen) begin hit = 1'b1; victim_dirty = 1'b0; end
        end
        if (!done) fail_now("request_timeout");
        mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0; victim_dirty = 1'b0;
        @(negedge clk);
        chk("hit_count",  hit_count,  m_hits);
        chk("miss_count", miss_count, m_miss);
        chk("wb_count",   wb_count,   m_wb);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 2'd0;
        end
        s_read = 1'b0; s_write = 1'b0; s_hit = 1'b0; s_vd = 1'b0; s_presp = 1'b0;
        // Reset with every request input active: outputs must stay low
        rst_n = 1'b0;
        mem_read = 1'b1; mem_write = 1'b1; hit = 1'b1; victim_dirty = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {21'd0, mem_resp, pmem_read, pmem_write, load_data, load_tag,
                              load_valid, load_dirty, dirty_in, datain_sel, pmem_addr_sel},
            32'd0);
        chk("reset_counters", {hit_count, miss_count} | {16'd0, wb_count}, 32'd0);
        mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0; victim_dirty = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        resp_en = 1'b1;

        // Directed: read miss clean, write hit, dirty victim, both-high hit
        do_req(3, 1, 1'b1, 1'b0, 1'b0);
        do_req(3, 1, 1'b0, 1'b1, 1'b0);
        do_req(3, 2, 1'b1, 1'b0, 1'b0);
        do_req(3, 2, 1'b1, 1'b1, 1'b0);
        do_req(7, 0, 1'b1, 1'b0, 1'b1);

        // Reset during ALLOCATE on an untouched line
        resp_en = 1'b0;
        @(posedge clk);
        #1;
        mem_read = 1'b1; hit = 1'b0; victim_dirty = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (pmem_read) seen = 1'b1;
        end
        if (!seen) fail_now("reach_allocate");
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {25'd0, pmem_read, pmem_write, mem_resp, load_data, load_tag,
                                load_valid, load_dirty}, 32'd0);
        chk("rst_mid_counters", {hit_count, miss_count} | {16'd0, wb_count}, 32'd0);
        m_hits = 0; m_miss = 0; m_wb = 0;
        exp_q.delete();
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        resp_en = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {30'd0, pmem_read, pmem_write}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            int op;
            op = $urandom_range(0, 2);
            do_req($urandom_range(0, 15), $urandom_range(0, 3), op != 1, op != 0,
                   $urandom_range(0, 7) == 0);
        end
        chk("queue_drained", exp_q.size(), 32'd0);

        // Saturation on the 4-bit counter instance
        @(posedge clk);
        #1;
        s_read = 1'b1; s_hit = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            chk("sat_resp", {31'd0, s_resp}, 32'd1);
            chk("sat_quiet", {23'd0, s_pr, s_pw, s_ld, s_lt, s_lv, s_ldy, s_din, s_dsel, s_asel},
                32'd0);
            @(posedge clk);
            #1;
            chk("sat_hit_count", {28'd0, s_hc}, (i > 15) ? 15 : i);
        end
        chk("sat_other_counts", {24'd0, s_mc, s_wc}, 32'd0);
        s_read = 1'b0; s_hit = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
